// File: rtl/multicycle_ctrl_if.sv
// Purpose : groups the controller's opcode/memory handshake inputs and datapath control outputs.
// Latency : none, wires only.
// Backpressure: the memory side stalls the controller by withholding mem_ack_i.
// Ports   : master = controller side (drives strobes), slave = datapath/memory side.
// Macro   : MULTICYCLE_CTRL_TIMEOUT_EN adds timeout_o.
interface multicycle_ctrl_if;
  logic [5:0] opcode_i;
  logic       mem_ack_i;
  logic       mem_req_o;
  logic       mem_read_o;
  logic       mem_write_o;
  logic       i_or_d_o;
  logic       ir_write_o;
  logic       pc_write_o;
  logic       pc_write_cond_o;
  logic       branch_ne_o;
  logic [1:0] pc_source_o;
  logic       alu_src_a_o;
  logic [1:0] alu_src_b_o;
  logic [2:0] alu_op_o;
  logic       reg_dst_o;
  logic       mem_to_reg_o;
  logic       reg_write_o;
  logic       retire_o;
  logic       illegal_o;
`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
  logic       timeout_o;
`endif

  modport master (
    input  opcode_i, mem_ack_i,
    output mem_req_o, mem_read_o, mem_write_o, i_or_d_o, ir_write_o, pc_write_o,
           pc_write_cond_o, branch_ne_o, pc_source_o, alu_src_a_o, alu_src_b_o,
           alu_op_o, reg_dst_o, mem_to_reg_o, reg_write_o, retire_o, illegal_o
`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
    , timeout_o
`endif
  );

  modport slave (
    output opcode_i, mem_ack_i,
    input  mem_req_o, mem_read_o, mem_write_o, i_or_d_o, ir_write_o, pc_write_o,
           pc_write_cond_o, branch_ne_o, pc_source_o, alu_src_a_o, alu_src_b_o,
           alu_op_o, reg_dst_o, mem_to_reg_o, reg_write_o, retire_o, illegal_o
`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
    , timeout_o
`endif
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Purpose : control FSM for the multi-cycle MIPS datapath (shared memory, ALU and PC adder).
// Latency : 3-5 cycles per instruction with zero-wait memory, plus any memory wait cycles.
// Backpressure: FETCH/MEM_RD/MEM_WR hold with mem_req_o high until mem_ack_i.
// Ports   : clk_i, rst_i (async, active-high); bus = multicycle_ctrl_if.master.
// Macro   : MULTICYCLE_CTRL_TIMEOUT_EN enables a bounded memory wait (MEM_TIMEOUT) and timeout_o.
module multicycle_ctrl
`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
  #(parameter int unsigned MEM_TIMEOUT = 15)
`endif
(
  input  logic              clk_i,
  input  logic              rst_i,
  multicycle_ctrl_if.master bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_ALU, S_MEM_ADDR,
    S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP, S_ILLEGAL, S_TIMEOUT
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] opc_q, opc_d;

`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       waiting;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      opc_q      <= '0;
`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
      wait_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      opc_q      <= opc_d;
`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
      wait_cnt_q <= wait_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d             = state_q;
    opc_d               = opc_q;
    bus.mem_req_o       = 1'b0;
    bus.mem_read_o      = 1'b0;
    bus.mem_write_o     = 1'b0;
    bus.i_or_d_o        = 1'b0;
    bus.ir_write_o      = 1'b0;
    bus.pc_write_o      = 1'b0;
    bus.pc_write_cond_o = 1'b0;
    bus.branch_ne_o     = 1'b0;
    bus.pc_source_o     = 2'b00;
    bus.alu_src_a_o     = 1'b0;
    bus.alu_src_b_o     = 2'b00;
    bus.alu_op_o        = 3'b000;
    bus.reg_dst_o       = 1'b0;
    bus.mem_to_reg_o    = 1'b0;
    bus.reg_write_o     = 1'b0;
    bus.retire_o        = 1'b0;
    bus.illegal_o       = 1'b0;
`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
    bus.timeout_o       = 1'b0;
`endif

    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        // PC+4 is computed every wait cycle but only committed with the IR load on ack.
        bus.mem_req_o   = 1'b1;
        bus.mem_read_o  = 1'b1;
        bus.alu_src_b_o = 2'b01;
        if (bus.mem_ack_i) begin
          bus.ir_write_o = 1'b1;
          bus.pc_write_o = 1'b1;
          state_d        = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target is precomputed here while the opcode is still being decoded.
        bus.alu_src_b_o = 2'b11;
        opc_d           = bus.opcode_i;
        case (bus.opcode_i)
          OP_RTYPE:        state_d = S_EXEC_R;
          OP_ADDI, OP_SLTI: state_d = S_EXEC_I;
          OP_LW, OP_SW:    state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:  state_d = S_BRANCH;
          OP_J:            state_d = S_JUMP;
          default:         state_d = S_ILLEGAL;
        endcase
      end
      S_EXEC_R: begin
        bus.alu_src_a_o = 1'b1;
        bus.alu_op_o    = 3'b010;
        state_d         = S_WB_ALU;
      end
      S_EXEC_I: begin
        bus.alu_src_a_o = 1'b1;
        bus.alu_src_b_o = 2'b10;
        bus.alu_op_o    = (opc_q == OP_SLTI) ? 3'b011 : 3'b000;
        state_d         = S_WB_ALU;
      end
      S_WB_ALU: begin
        bus.reg_write_o = 1'b1;
        bus.reg_dst_o   = (opc_q == OP_RTYPE);
        bus.retire_o    = 1'b1;
        state_d         = S_FETCH;
      end
      S_MEM_ADDR: begin
        bus.alu_src_a_o = 1'b1;
        bus.alu_src_b_o = 2'b10;
        state_d         = (opc_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        bus.mem_req_o  = 1'b1;
        bus.mem_read_o = 1'b1;
        bus.i_or_d_o   = 1'b1;
        if (bus.mem_ack_i) state_d = S_WB_MEM;
      end
      S_WB_MEM: begin
        bus.reg_write_o  = 1'b1;
        bus.mem_to_reg_o = 1'b1;
        bus.retire_o     = 1'b1;
        state_d          = S_FETCH;
      end
      S_MEM_WR: begin
        bus.mem_req_o   = 1'b1;
        bus.mem_write_o = 1'b1;
        bus.i_or_d_o    = 1'b1;
        if (bus.mem_ack_i) begin
          bus.retire_o = 1'b1;
          state_d      = S_FETCH;
        end
      end
      S_BRANCH: begin
        bus.alu_src_a_o     = 1'b1;
        bus.alu_op_o        = 3'b001;
        bus.pc_write_cond_o = 1'b1;
        bus.pc_source_o     = 2'b01;
        bus.branch_ne_o     = (opc_q == OP_BNE);
        bus.retire_o        = 1'b1;
        state_d             = S_FETCH;
      end
      S_JUMP: begin
        bus.pc_write_o  = 1'b1;
        bus.pc_source_o = 2'b10;
        bus.retire_o    = 1'b1;
        state_d         = S_FETCH;
      end
      S_ILLEGAL: bus.illegal_o = 1'b1;
`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
      S_TIMEOUT: bus.timeout_o = 1'b1;
`endif
      default: state_d = S_IDLE;
    endcase

`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
    // wait_cnt_q holds the number of earlier ack-less cycles in this wait, so the
    // MEM_TIMEOUT-th ack-less cycle is the one that sees MEM_TIMEOUT-1. Ack wins.
    waiting = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    if (waiting && !bus.mem_ack_i && (wait_cnt_q == 4'(MEM_TIMEOUT - 1)))
      state_d = S_TIMEOUT;
    if (state_d != state_q)
      wait_cnt_d = '0;
    else if (waiting && !bus.mem_ack_i)
      wait_cnt_d = wait_cnt_q + 4'd1;
    else
      wait_cnt_d = wait_cnt_q;
`endif
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: each instruction is expanded into its expected
// per-cycle control words (with the memory acks to drive) and compared every cycle.
module tb_multicycle_ctrl;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef struct packed {
    logic       mem_req, mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, branch_ne;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       reg_dst, mem_to_reg, reg_write, retire, illegal;
  } ctl_t;

  typedef struct packed {
    logic       ack;
    logic [5:0] opc;
    ctl_t       ctl;
  } step_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  multicycle_ctrl_if bus();
  multicycle_ctrl dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

  int    n_tests = 0;
  int    n_fail  = 0;
  step_t exp_q[$];
  int    step_no = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic ctl_t observed();
    ctl_t c;
    c.mem_req = bus.mem_req_o;         c.mem_read = bus.mem_read_o;
    c.mem_write = bus.mem_write_o;     c.i_or_d = bus.i_or_d_o;
    c.ir_write = bus.ir_write_o;       c.pc_write = bus.pc_write_o;
    c.pc_write_cond = bus.pc_write_cond_o; c.branch_ne = bus.branch_ne_o;
    c.pc_source = bus.pc_source_o;     c.alu_src_a = bus.alu_src_a_o;
    c.alu_src_b = bus.alu_src_b_o;     c.alu_op = bus.alu_op_o;
    c.reg_dst = bus.reg_dst_o;         c.mem_to_reg = bus.mem_to_reg_o;
    c.reg_write = bus.reg_write_o;     c.retire = bus.retire_o;
    c.illegal = bus.illegal_o;
    return c;
  endfunction

  function automatic logic [5:0] rnd6();
    return 6'($urandom);
  endfunction

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  task automatic push(input logic ack, input logic [5:0] opc, input ctl_t c);
    step_t s;
    s.ack = ack; s.opc = opc; s.ctl = c;
    exp_q.push_back(s);
  endtask

  // A memory access: 'waits' ack-less cycles, then the ack cycle (ack_extra added there).
  task automatic add_mem(input int waits, input ctl_t c, input ctl_t ack_extra);
    repeat (waits) push(1'b0, rnd6(), c);
    push(1'b1, rnd6(), c | ack_extra);
  endtask

  // Expected cycles of one instruction. The opcode is only meaningful in the decode
  // cycle; all other cycles drive junk to prove the controller uses its latched copy.
  task automatic add_instr(input logic [5:0] op, input int fw, input int mw);
    ctl_t c, x;
    c = '0; c.mem_req = 1; c.mem_read = 1; c.alu_src_b = 2'b01;
    x = '0; x.ir_write = 1; x.pc_write = 1;
    add_mem(fw, c, x);
    c = '0; c.alu_src_b = 2'b11;
    push(rbit(), op, c);
    c = '0;
    case (op)
      OP_RTYPE, OP_ADDI, OP_SLTI: begin
        c.alu_src_a = 1;
        c.alu_src_b = (op == OP_RTYPE) ? 2'b00 : 2'b10;
        c.alu_op = (op == OP_RTYPE) ? 3'b010 : (op == OP_SLTI) ? 3'b011 : 3'b000;
        push(rbit(), rnd6(), c);
        c = '0; c.reg_write = 1; c.reg_dst = (op == OP_RTYPE); c.retire = 1;
        push(rbit(), rnd6(), c);
      end
      OP_LW, OP_SW: begin
        c.alu_src_a = 1; c.alu_src_b = 2'b10;
        push(rbit(), rnd6(), c);
        c = '0; c.mem_req = 1; c.i_or_d = 1; x = '0;
        if (op == OP_LW) begin
          c.mem_read = 1;
          add_mem(mw, c, x);
          c = '0; c.reg_write = 1; c.mem_to_reg = 1; c.retire = 1;
          push(rbit(), rnd6(), c);
        end else begin
          c.mem_write = 1; x.retire = 1;
          add_mem(mw, c, x);
        end
      end
      OP_BEQ, OP_BNE: begin
        c.alu_src_a = 1; c.alu_op = 3'b001; c.pc_write_cond = 1;
        c.pc_source = 2'b01; c.branch_ne = (op == OP_BNE); c.retire = 1;
        push(rbit(), rnd6(), c);
      end
      OP_J: begin
        c.pc_write = 1; c.pc_source = 2'b10; c.retire = 1;
        push(rbit(), rnd6(), c);
      end
      default: begin
        c.illegal = 1;
        repeat (20) push(rbit(), rnd6(), c);
      end
    endcase
  endtask

  // Drives and checks up to max_n expected cycles from the queue.
  task automatic run(input string tag, input int max_n);
    step_t s;
    int    n;
    n = 0;
    while (exp_q.size() > 0 && n < max_n) begin
      s = exp_q.pop_front();
      @(posedge clk_i); #1;
      bus.mem_ack_i = s.ack;
      bus.opcode_i  = s.opc;
      @(negedge clk_i);
      step_no++;
      check($sformatf("%s@%0d", tag, step_no), 32'(observed()), 32'(s.ctl));
`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
      check($sformatf("%s_tmo@%0d", tag, step_no), 32'(bus.timeout_o), 32'd0);
`endif
      n++;
    end
  endtask

  // Asserts reset shortly after an edge and checks outputs well before the next one.
  task automatic reset_dut(input string tag);
    exp_q.delete();
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    bus.mem_ack_i = 1'b0;
    #1;
    check({tag, "_async"}, 32'(observed()), 32'd0);
`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
    check({tag, "_async_tmo"}, 32'(bus.timeout_o), 32'd0);
`endif
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check({tag, "_idle"}, 32'(observed()), 32'd0);
  endtask

  logic [5:0] legal_ops [8];

  initial begin
    bus.opcode_i  = '0;
    bus.mem_ack_i = 1'b0;
    legal_ops = '{OP_RTYPE, OP_ADDI, OP_SLTI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J};

    reset_dut("reset");

    add_instr(OP_RTYPE, 0, 0); run("add", 100);
    add_instr(OP_LW, 3, 2);    run("lw_wait", 100);
    add_instr(OP_SW, 1, 0);    run("sw", 100);
    add_instr(OP_BNE, 0, 0);   run("bne", 100);
    add_instr(OP_BEQ, 0, 0);   run("beq", 100);
    add_instr(OP_J, 0, 0);     run("j", 100);
    add_instr(OP_SLTI, 0, 0);  run("slti", 100);

    for (int i = 0; i < 60; i++) begin
      add_instr(legal_ops[$urandom_range(0, 7)], $urandom_range(0, 4), $urandom_range(0, 4));
      run("rand", 100);
    end

    add_instr(6'b111111, 0, 0); run("illegal", 100);
    reset_dut("illegal_clr");

    // Stop partway through an 8-cycle MEM_RD wait (fetch, decode, addr, 4 waits).
    add_instr(OP_LW, 0, 8); run("lw_mid", 7);
    reset_dut("rst_mid_rd");

    add_instr(OP_ADDI, 2, 0); run("after_rst", 100);

`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
    begin
      ctl_t c;
      reset_dut("pre_tmo");
      c = '0; c.mem_req = 1; c.mem_read = 1; c.alu_src_b = 2'b01;
      repeat (15) push(1'b0, rnd6(), c);
      run("tmo_wait", 15);
      for (int k = 0; k < 5; k++) begin
        @(posedge clk_i); #1;
        bus.mem_ack_i = rbit();
        @(negedge clk_i);
        check("timeout_ctl", 32'(observed()), 32'd0);
        check("timeout_o", 32'(bus.timeout_o), 32'd1);
      end
      reset_dut("tmo_clr");
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
